// File: rtl/irq_acknowledger.sv
// -----------------------------------------------------------------------------
// irq_acknowledger
//
// CPU-side interrupt acknowledge sequencer for the 68k-style core.
//
// The encoded, active-low ipl_n lines are synchronised and de-glitched into
// lvl_q. The CPU compares lvl_q against its status-register mask; level 7 is
// also edge-latched so it can be taken even when the mask is 7. At an
// instruction boundary the block runs the acknowledge handshake. The
// controller answers with dtack plus a vector byte, or with avec_n to request
// an autovector. If neither arrives within TIMEOUT cycles, the spurious vector
// is forced. The resulting vector is handed to the exception unit with a
// one-cycle vector_valid pulse. A guard interval after each acknowledge lets
// the controller's level fall before a new cycle can start.
//
// Ports
//   clk          in   1  clock
//   reset        in   1  synchronous, active-high reset
//   ipl_n        in   3  encoded interrupt level, active-low (3'b111 = none)
//   sr_mask      in   3  CPU interrupt mask
//   boundary     in   1  one-cycle strobe, CPU at an instruction boundary
//   dtack        in   1  active-low acknowledge; data_i valid while low
//   avec_n       in   1  active-low autovector request
//   data_i       in   8  vector byte from the controller
//   ack          out  1  interrupt-acknowledge cycle in progress
//   iack_level   out  3  level being acknowledged
//   irq_pending  out  1  interrupt eligible (combinational)
//   vector_o     out  8  last acknowledged vector, held until the next one
//   vector_valid out  1  one-cycle pulse, vector_o is fresh
//   spurious     out  1  with vector_valid: vector came from the timeout
//   busy         out  1  sequencer not idle
// -----------------------------------------------------------------------------
module irq_acknowledger #(
   parameter int         TIMEOUT      = 64,
   parameter int         GUARD        = 5,
   parameter logic [7:0] SPURIOUS_VEC = 8'd24,
   parameter logic [7:0] AUTOVEC_BASE = 8'd25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] ipl_n,
   input  logic [2:0] sr_mask,
   input  logic       boundary,
   input  logic       dtack,
   input  logic       avec_n,
   input  logic [7:0] data_i,
   output logic       ack,
   output logic [2:0] iack_level,
   output logic       irq_pending,
   output logic [7:0] vector_o,
   output logic       vector_valid,
   output logic       spurious,
   output logic       busy
);

   // The counter serves both the ACK timeout and the GUARD interval.
   localparam int CNT_MAX = (TIMEOUT > GUARD) ? TIMEOUT : GUARD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACK,
      S_DONE,
      S_GUARD
   } state_t;

   // ---------------------------------------------------------------------------
   // Level path: two-flop synchroniser, then a one-stage candidate register.
   // lvl_q only takes the candidate when it agrees with the next sample, so a
   // level that is present for a single cycle never reaches lvl_q.
   // ---------------------------------------------------------------------------
   logic [2:0] s1;
   logic [2:0] s2;
   logic [2:0] cand;
   logic [2:0] lvl_q;
   logic       lvl_accept;

   assign lvl_accept = (cand == ~s2);

   // NOTE: sequential state uses non-blocking assignments, and reset is
   // sampled only on the clock edge, so it is tested inside the clocked block.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1    <= 3'b111;
         s2    <= 3'b111;
         cand  <= 3'd0;
         lvl_q <= 3'd0;
      end else begin
         s1   <= ipl_n;
         s2   <= s1;
         cand <= ~s2;
         if (lvl_accept) begin
            lvl_q <= cand;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Level-7 edge latch. Level 7 cannot be masked, so it is taken on its
   // rising edge even when sr_mask is 7. Holding it does not re-trigger.
   // ---------------------------------------------------------------------------
   state_t state_q;
   state_t state_d;
   logic   nmi_latch;
   logic   nmi_set;
   logic   nmi_clr;
   logic   take_irq;

   assign nmi_set = lvl_accept && (cand == 3'd7) && (lvl_q != 3'd7);
   assign nmi_clr = take_irq && (lvl_q == 3'd7);

   always_ff @(posedge clk) begin
      if (reset) begin
         nmi_latch <= 1'b0;
      end else if (nmi_set) begin
         nmi_latch <= 1'b1;
      end else if (nmi_clr) begin
         nmi_latch <= 1'b0;
      end
   end

   assign irq_pending = (state_q == S_IDLE) &&
                        (((lvl_q != 3'd0) && (lvl_q > sr_mask)) || nmi_latch);
   assign take_irq    = boundary && irq_pending;

   // ---------------------------------------------------------------------------
   // Acknowledge sequencer
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             ack_d;
   logic [2:0]       level_d;
   logic [7:0]       vector_d;
   logic             valid_d;
   logic             spurious_d;
   logic             resp_ok;
   logic             ack_end;
   logic [7:0]       autovec;

   // The first ACK cycle has cnt_q == 0. Responses there may still reflect the
   // previous bus cycle, so they are ignored.
   assign resp_ok = (cnt_q != '0);
   assign autovec = AUTOVEC_BASE + {5'd0, iack_level} - 8'd1;

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ack_d      = ack;
      level_d    = iack_level;
      vector_d   = vector_o;
      valid_d    = 1'b0;
      spurious_d = 1'b0;
      ack_end    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (take_irq) begin
               level_d = lvl_q;
               ack_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_ACK;
            end
         end

         S_ACK: begin
            cnt_d = cnt_q + CNT_W'(1);
            // A data response wins over an autovector request, and both win
            // over a timeout that coincides with them.
            if (resp_ok && !dtack) begin
               vector_d = data_i;
               ack_end  = 1'b1;
            end else if (resp_ok && !avec_n) begin
               vector_d = autovec;
               ack_end  = 1'b1;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               vector_d   = SPURIOUS_VEC;
               spurious_d = 1'b1;
               ack_end    = 1'b1;
            end
            if (ack_end) begin
               ack_d   = 1'b0;
               valid_d = 1'b1;
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            cnt_d   = '0;
            state_d = (GUARD == 0) ? S_IDLE : S_GUARD;
         end

         S_GUARD: begin
            // Keeps a stale lvl_q from re-triggering until the controller's
            // drop of ipl has passed through the synchroniser.
            if (cnt_q == CNT_W'(GUARD - 1)) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            cnt_d   = '0;
            ack_d   = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         ack          <= 1'b0;
         iack_level   <= 3'd0;
         vector_o     <= 8'd0;
         vector_valid <= 1'b0;
         spurious     <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ack          <= ack_d;
         iack_level   <= level_d;
         vector_o     <= vector_d;
         vector_valid <= valid_d;
         spurious     <= spurious_d;
         busy         <= (state_d != S_IDLE);
      end
   end

endmodule

// File: doc/irq_acknowledger.md
# irq_acknowledger

CPU-side interrupt acknowledge sequencer for the 68k-style core. It samples the encoded, active-low `ipl_n` lines driven by the interrupt controller and compares the level against the CPU status-register mask. At an instruction boundary it runs the interrupt-acknowledge handshake (`ack` / `dtack` / vector byte) and hands the resulting vector to the exception unit, with autovector and timeout (spurious) fallbacks.

## Interface
- `TIMEOUT`, 64: cycles in ACK without `dtack`/`avec_n` before the spurious vector is forced; ≥ 4.
- `GUARD`, 5: cycles after DONE during which no new acknowledge may start.
- `SPURIOUS_VEC`, 8'd24: vector reported on timeout.
- `AUTOVEC_BASE`, 8'd25: vector for level 1 on autovector; level L gives `AUTOVEC_BASE+L-1`.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `ipl_n`  in  3  encoded interrupt level, active-low (3'b111 = none)
- `sr_mask`  in  3  CPU interrupt mask
- `boundary`  in  1  one-cycle strobe: CPU at instruction boundary, may take interrupt
- `dtack`  in  1  active-low acknowledge from controller; `data_i` valid while low
- `avec_n`  in  1  active-low autovector request
- `data_i`  in  8  vector byte from controller
- `ack`  out  1  interrupt-acknowledge cycle in progress
- `iack_level`  out  3  level being acknowledged
- `irq_pending`  out  1  interrupt eligible (combinational from state, `lvl_q`, `sr_mask`, `nmi_latch`)
- `vector_o`  out  8  last acknowledged vector, held until next DONE
- `vector_valid`  out  1  one-cycle pulse, `vector_o` fresh
- `spurious`  out  1  with `vector_valid`: vector came from timeout
- `busy`  out  1  state ≠ IDLE

## Operation
- Level path: `s1 <= ipl_n`; `s2 <= s1`; `cand <= ~s2`; `lvl_q <= cand` only when `cand == ~s2`, which filters one-cycle glitches. Reset clears `s1`/`s2` to 3'b111 and `cand`/`lvl_q` to 0.
- `nmi_latch`:
  - Set when `lvl_q` becomes 7 from < 7.
  - Cleared on entry to ACK with level 7, and on reset.
- `irq_pending` = state IDLE && ((`lvl_q` != 0 && `lvl_q` > `sr_mask`) || `nmi_latch`). Level 7 with `sr_mask` = 7 is taken only via `nmi_latch` (edge-triggered).
- States:
  - **IDLE**: on `boundary && irq_pending`, latch L = `lvl_q` into `iack_level`, set `ack`, clear the counter, go to ACK.
  - **ACK**:
    - Counter increments every cycle. The first ACK cycle ignores `dtack` and `avec_n`.
    - From cycle 2, priority `dtack`==0 > `avec_n`==0 > counter == `TIMEOUT-1`:
      - `dtack` low: `vector_o <= data_i`.
      - `avec_n` low: `vector_o <= AUTOVEC_BASE+L-1` (8-bit wrap).
      - Timeout: `vector_o <= SPURIOUS_VEC`, `spurious <= 1`.
    - Each outcome clears `ack` and moves to DONE.
  - **DONE** (1 cycle): `vector_valid` = 1, `spurious` as set. Go to GUARD with counter cleared.
  - **GUARD**: wait `GUARD` cycles so stale `lvl_q` is not re-taken (the controller drops ipl one cycle after `ack` falls, plus 4 cycles of sync). Then go to IDLE.
- `sr_mask`/`ipl_n` changes during ACK/DONE/GUARD do not affect `iack_level`.
- If the level drops below the mask before `boundary`, no cycle runs.
- `boundary` outside IDLE is ignored.
- Reset (any state, including mid-ACK): next edge `ack`=0, `vector_valid`=0, `spurious`=0, `busy`=0, `iack_level`=0, `vector_o`=0, state IDLE, `nmi_latch`=0.

## Timing
- Stable `ipl_n` change to `lvl_q`: 4 edges. `irq_pending` follows `lvl_q` combinationally.
- `boundary` at edge E0 ⇒ `ack` high after E0. `dtack` is sampled low at earliest at E2. Then `ack` is low and `vector_valid` is high after that edge (DONE) for exactly one cycle.
- With the companion controller (registered `ack`, data, and `dtack`), `dtack` arrives on the 2nd ACK cycle, so `ack` is high for 2 cycles.
- Timeout: `ack` is high for exactly `TIMEOUT` cycles.
- Earliest next `ack`: 1 (DONE) + `GUARD` + 1 cycles after `ack` falls.
- Outputs are registered except `irq_pending`.

## Test plan
- `ipl_n`=3'b010 (level 5), `sr_mask`=3, `boundary` pulse, controller returns 8'h40 on 2nd ACK cycle ⇒ `ack` high 2 cycles, `iack_level`=5, `vector_o`=8'h40, `vector_valid` 1 cycle, `spurious`=0.
- Level 3 with `sr_mask`=3 ⇒ `irq_pending`=0 and `boundary` starts nothing. Lower `sr_mask` to 2 ⇒ cycle runs.
- Level 2, no `dtack`, `avec_n` low on 2nd ACK cycle ⇒ `vector_o`=26. No response at all ⇒ `ack` high 64 cycles, `vector_o`=24, `spurious`=1.
- Level 7 with `sr_mask`=7 ⇒ taken once. Holding level 7 does not re-trigger. Drop to 0 then back to 7 ⇒ taken again.
- One-cycle glitch `ipl_n`=3'b000 ⇒ `lvl_q` unchanged, no `irq_pending`.
- Reset asserted on 2nd ACK cycle with `dtack` low ⇒ `ack`=0, no `vector_valid`, `vector_o`=0. `dtack` and `avec_n` low together ⇒ `data_i` is used.
